// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the core ALU and the two-port ALU share
// arbiter.
//   - ALUC opcode constants (5-bit encoding shared across the codebase)
//   - alu_req_t : operand/opcode bundle presented to the ALU
//   - alu_rsp_t : result plus zero/carry/sign flags returned by the ALU
//   - port_t    : names the two requesters (used for the round-robin pointer)
package alu_pkg;

    // Number of requesters sharing the ALU; fixed by the design.
    localparam int NPORT = 2;

    localparam logic [4:0] ALUC_ADDU  = 5'd0;
    localparam logic [4:0] ALUC_ADD   = 5'd1;
    localparam logic [4:0] ALUC_SUBU  = 5'd2;
    localparam logic [4:0] ALUC_SUB   = 5'd3;
    localparam logic [4:0] ALUC_AND   = 5'd4;
    localparam logic [4:0] ALUC_OR    = 5'd5;
    localparam logic [4:0] ALUC_XOR   = 5'd6;
    localparam logic [4:0] ALUC_NOR   = 5'd7;
    localparam logic [4:0] ALUC_LUI   = 5'd8;
    localparam logic [4:0] ALUC_LUI_B = 5'd9;
    localparam logic [4:0] ALUC_SLT   = 5'd10;
    localparam logic [4:0] ALUC_SLTU  = 5'd11;
    localparam logic [4:0] ALUC_SRA   = 5'd12;
    localparam logic [4:0] ALUC_SLL   = 5'd13;
    localparam logic [4:0] ALUC_SLA   = 5'd14;
    localparam logic [4:0] ALUC_SRL   = 5'd15;
    localparam logic [4:0] ALUC_MUL   = 5'd16;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  aluc;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        carry;
        logic        sign;
    } alu_rsp_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational 32-bit ALU.
//   req : operands a, b and 5-bit opcode (alu_pkg encoding)
//   rsp : 32-bit result and flags
// Flags:
//   zero  - result is all zeros
//   carry - carry out of ADD/ADDU, borrow of SUB/SUBU, a<b (unsigned) for SLTU
//   sign  - signed a<b for SLT, otherwise bit 31 of the result
// Shifts move operand b by a[4:0]. MUL keeps the low 32 bits of the product.
// Undefined opcodes produce a zero result.
module alu_core
    import alu_pkg::*;
(
    input  alu_req_t req,
    output alu_rsp_t rsp
);

    logic [32:0] wide;
    logic [31:0] res;
    logic        carry;
    logic        lt_signed;

    // Opcode decode; the 33-bit sum/difference provides carry and borrow.
    always_comb begin
        wide      = '0;
        res       = '0;
        carry     = 1'b0;
        lt_signed = 1'b0;
        case (req.aluc)
            ALUC_ADDU, ALUC_ADD: begin
                wide  = {1'b0, req.a} + {1'b0, req.b};
                res   = wide[31:0];
                carry = wide[32];
            end
            ALUC_SUBU, ALUC_SUB: begin
                wide  = {1'b0, req.a} - {1'b0, req.b};
                res   = wide[31:0];
                carry = wide[32];
            end
            ALUC_AND:   res = req.a & req.b;
            ALUC_OR:    res = req.a | req.b;
            ALUC_XOR:   res = req.a ^ req.b;
            ALUC_NOR:   res = ~(req.a | req.b);
            ALUC_LUI, ALUC_LUI_B: res = {req.b[15:0], 16'h0000};
            ALUC_SLT: begin
                lt_signed = $signed(req.a) < $signed(req.b);
                res       = {31'd0, lt_signed};
            end
            ALUC_SLTU: begin
                carry = req.a < req.b;
                res   = {31'd0, carry};
            end
            ALUC_SRA:   res = $signed(req.b) >>> req.a[4:0];
            ALUC_SLL, ALUC_SLA: res = req.b << req.a[4:0];
            ALUC_SRL:   res = req.b >> req.a[4:0];
            ALUC_MUL:   res = req.a * req.b;
            default:    res = '0;
        endcase

        rsp.res   = res;
        rsp.zero  = (res == 32'd0);
        rsp.carry = carry;
        rsp.sign  = (req.aluc == ALUC_SLT) ? lt_signed : res[31];
    end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : per-port eligibility
//   grant      : one-hot grant (all zero when nothing is eligible)
// The last_grant pointer resets to PORT1 so that port 0 wins the first
// contention. It only moves when a grant is actually issued.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    port_t last_grant;

    // A lone requester always wins; on contention the port that did not
    // win last time is served.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
        end
    end

    // Remember the most recent winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT1;
        end else if (grant[1]) begin
            last_grant <= PORT1;
        end else if (grant[0]) begin
            last_grant <= PORT0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one alu_core between two requesters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-port request handshake (ready == grant)
//   req_a/req_b/req_aluc : per-port operands and opcode
//   req_tag              : opaque tag echoed on the response
//   rsp_valid/rsp_ready  : per-port response handshake
//   rsp_res, rsp_zero, rsp_carry, rsp_sign, rsp_tag : registered response
//   grant_cnt            : per-port saturating grant counter
// One grant per cycle, round-robin on contention. A port whose response slot
// is full and not being drained cannot be granted.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int TAGW = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NPORT-1:0]           req_valid,
    output logic [NPORT-1:0]           req_ready,
    input  logic [NPORT-1:0][31:0]     req_a,
    input  logic [NPORT-1:0][31:0]     req_b,
    input  logic [NPORT-1:0][4:0]      req_aluc,
    input  logic [NPORT-1:0][TAGW-1:0] req_tag,
    output logic [NPORT-1:0]           rsp_valid,
    input  logic [NPORT-1:0]           rsp_ready,
    output logic [NPORT-1:0][31:0]     rsp_res,
    output logic [NPORT-1:0]           rsp_zero,
    output logic [NPORT-1:0]           rsp_carry,
    output logic [NPORT-1:0]           rsp_sign,
    output logic [NPORT-1:0][TAGW-1:0] rsp_tag,
    output logic [NPORT-1:0][15:0]     grant_cnt
);

    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] grant;
    alu_req_t         alu_req;
    alu_rsp_t         alu_rsp;

    // A port may be served when its response slot is empty or being
    // drained in this same cycle.
    always_comb begin
        eligible = req_valid & (~rsp_valid | rsp_ready);
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .grant (grant)
    );

    assign req_ready = grant;

    // Operand mux; with no grant the ALU inputs are don't-care, so port 0
    // is simply left selected.
    always_comb begin
        alu_req.a    = req_a[0];
        alu_req.b    = req_b[0];
        alu_req.aluc = req_aluc[0];
        if (grant[1]) begin
            alu_req.a    = req_a[1];
            alu_req.b    = req_b[1];
            alu_req.aluc = req_aluc[1];
        end
    end

    alu_core u_alu (
        .req (alu_req),
        .rsp (alu_rsp)
    );

    // Response slots: a grant overwrites the slot (even while it is being
    // drained), otherwise a drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_zero  <= '0;
            rsp_carry <= '0;
            rsp_sign  <= '0;
            rsp_tag   <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (grant[p]) begin
                    rsp_valid[p] <= 1'b1;
                    rsp_res[p]   <= alu_rsp.res;
                    rsp_zero[p]  <= alu_rsp.zero;
                    rsp_carry[p] <= alu_rsp.carry;
                    rsp_sign[p]  <= alu_rsp.sign;
                    rsp_tag[p]   <= req_tag[p];
                end else if (rsp_ready[p]) begin
                    rsp_valid[p] <= 1'b0;
                end
            end
        end
    end

    // Grant counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (grant[p] && (grant_cnt[p] != 16'hFFFF)) begin
                    grant_cnt[p] <= grant_cnt[p] + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: self-checking bench for alu_share_arbiter.
// Directed vector table, hand-written corner sequences, and a randomized
// phase compared against a behavioural model of the arbiter and ALU.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int TAGW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            req_valid, req_ready;
    logic [1:0][31:0]      req_a, req_b;
    logic [1:0][4:0]       req_aluc;
    logic [1:0][TAGW-1:0]  req_tag;
    logic [1:0]            rsp_valid, rsp_ready;
    logic [1:0][31:0]      rsp_res;
    logic [1:0]            rsp_zero, rsp_carry, rsp_sign;
    logic [1:0][TAGW-1:0]  rsp_tag;
    logic [1:0][15:0]      grant_cnt;

    alu_share_arbiter #(.TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_aluc  (req_aluc),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
        .rsp_sign  (rsp_sign),
        .rsp_tag   (rsp_tag),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [1:0]      mdl_valid;
    logic [31:0]     mdl_res [2];
    logic            mdl_z [2], mdl_c [2], mdl_s [2];
    logic [TAGW-1:0] mdl_tag [2];
    int              mdl_cnt [2];
    int              mdl_last;
    int              last_w;

    bit              do_check   = 1'b1;
    bit              exp_rdy_en = 1'b0;
    logic [1:0]      exp_rdy;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        s;
    } ref_t;

    typedef struct packed {
        logic [4:0]      aluc;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [TAGW-1:0] tag;
        logic [31:0]     res;
        logic            z;
        logic            c;
        logic            s;
    } vec_t;

    vec_t vecs[$];

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic ref_t ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        ref_t        r;
        logic [63:0] wide;
        int          sh;
        r    = '0;
        sh   = int'(a[4:0]);
        wide = '0;
        case (op)
            ALUC_ADDU, ALUC_ADD: begin
                wide  = {32'd0, a} + {32'd0, b};
                r.res = wide[31:0];
                r.c   = wide[32];
            end
            ALUC_SUBU, ALUC_SUB: begin
                r.res = a - b;
                r.c   = (a < b);
            end
            ALUC_AND:  r.res = a & b;
            ALUC_OR:   r.res = a | b;
            ALUC_XOR:  r.res = a ^ b;
            ALUC_NOR:  r.res = ~(a | b);
            ALUC_LUI, ALUC_LUI_B: r.res = b << 16;
            ALUC_SLT:  r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALUC_SLTU: begin
                r.res = (a < b) ? 32'd1 : 32'd0;
                r.c   = (a < b);
            end
            ALUC_SRA:  r.res = $signed(b) >>> sh;
            ALUC_SLL, ALUC_SLA: r.res = b << sh;
            ALUC_SRL:  r.res = b >> sh;
            ALUC_MUL: begin
                wide  = {32'd0, a} * {32'd0, b};
                r.res = wide[31:0];
            end
            default:   r.res = 32'd0;
        endcase
        r.z = (r.res == 32'd0);
        r.s = (op == ALUC_SLT) ? r.res[0] : r.res[31];
        return r;
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAGW-1:0] tag, input logic [31:0] res,
                                input logic z, input logic c, input logic s);
        vec_t v;
        v.aluc = op; v.a = a; v.b = b; v.tag = tag;
        v.res = res; v.z = z; v.c = c; v.s = s;
        return v;
    endfunction

    task automatic model_reset();
        mdl_valid = '0;
        for (int p = 0; p < 2; p++) begin
            mdl_res[p] = '0; mdl_z[p] = 0; mdl_c[p] = 0; mdl_s[p] = 0;
            mdl_tag[p] = '0; mdl_cnt[p] = 0;
        end
        mdl_last = 1;
    endtask

    // Winner under the current inputs and model state, or -1 for none.
    function automatic int predict_winner();
        bit e [2];
        for (int p = 0; p < 2; p++)
            e[p] = req_valid[p] && (!mdl_valid[p] || rsp_ready[p]);
        if (e[0] && e[1]) return 1 - mdl_last;
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    task automatic model_update();
        ref_t r;
        int   w;
        w = predict_winner();
        for (int p = 0; p < 2; p++) begin
            if (p == w) begin
                r = ref_alu(req_aluc[p], req_a[p], req_b[p]);
                mdl_valid[p] = 1'b1;
                mdl_res[p] = r.res; mdl_z[p] = r.z; mdl_c[p] = r.c; mdl_s[p] = r.s;
                mdl_tag[p] = req_tag[p];
                if (mdl_cnt[p] < 65535) mdl_cnt[p]++;
            end else if (mdl_valid[p] && rsp_ready[p]) begin
                mdl_valid[p] = 1'b0;
            end
        end
        if (w >= 0) mdl_last = w;
        last_w = w;
    endtask

    task automatic checkOutput();
        int         w;
        logic [1:0] er;
        w  = predict_winner();
        er = (w < 0) ? 2'b00 : (2'b01 << w);
        compare("req_ready", req_ready, er);
        for (int p = 0; p < 2; p++) begin
            compare($sformatf("rsp_valid[%0d]", p), rsp_valid[p], mdl_valid[p]);
            compare($sformatf("rsp_res[%0d]", p), rsp_res[p], mdl_res[p]);
            compare($sformatf("flags[%0d]", p), {rsp_zero[p], rsp_carry[p], rsp_sign[p]},
                    {mdl_z[p], mdl_c[p], mdl_s[p]});
            compare($sformatf("rsp_tag[%0d]", p), rsp_tag[p], mdl_tag[p]);
            compare($sformatf("grant_cnt[%0d]", p), grant_cnt[p], mdl_cnt[p]);
        end
    endtask

    task automatic applyStimulus(input int p, input logic v, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic [TAGW-1:0] tag);
        req_valid[p] = v;
        req_aluc[p]  = op;
        req_a[p]     = a;
        req_b[p]     = b;
        req_tag[p]   = tag;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic run_cycle();
        @(negedge clk);
        if (do_check) checkOutput();
        if (exp_rdy_en) compare("ready_seq", req_ready, exp_rdy);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] held_cnt;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_aluc  = '0;
        req_tag   = '0;
        rsp_ready = '0;
        model_reset();

        // Reset values while rst_n is low
        #12;
        compare("rst_valid", rsp_valid, 2'b00);
        compare("rst_res", rsp_res, 64'd0);
        compare("rst_flags", {rsp_zero, rsp_carry, rsp_sign}, 6'd0);
        compare("rst_tag", rsp_tag, 8'd0);
        compare("rst_cnt", grant_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vector table on port 0, streamed back to back
        vecs.push_back(mk(ALUC_ADD,  32'd5,        32'd7,        4'd3,  32'd12,       0, 0, 0));
        vecs.push_back(mk(ALUC_SUB,  32'd9,        32'd9,        4'd4,  32'd0,        1, 0, 0));
        vecs.push_back(mk(ALUC_SUBU, 32'd1,        32'd2,        4'd5,  32'hFFFFFFFF, 0, 1, 1));
        vecs.push_back(mk(ALUC_ADDU, 32'hFFFFFFFF, 32'd1,        4'd6,  32'd0,        1, 1, 0));
        vecs.push_back(mk(ALUC_AND,  32'hF0F0F0F0, 32'hFF00FF00, 4'd7,  32'hF000F000, 0, 0, 1));
        vecs.push_back(mk(ALUC_OR,   32'h000000F0, 32'h0000000F, 4'd8,  32'h000000FF, 0, 0, 0));
        vecs.push_back(mk(ALUC_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 4'd9,  32'hF0F00F0F, 0, 0, 1));
        vecs.push_back(mk(ALUC_NOR,  32'd0,        32'd0,        4'd10, 32'hFFFFFFFF, 0, 0, 1));
        vecs.push_back(mk(ALUC_LUI,  32'd0,        32'h00001234, 4'd11, 32'h12340000, 0, 0, 0));
        vecs.push_back(mk(ALUC_LUI_B,32'd0,        32'h0000ABCD, 4'd12, 32'hABCD0000, 0, 0, 1));
        vecs.push_back(mk(ALUC_SLT,  32'hFFFFFFFF, 32'd1,        4'd13, 32'd1,        0, 0, 1));
        vecs.push_back(mk(ALUC_SLTU, 32'hFFFFFFFF, 32'd1,        4'd14, 32'd0,        1, 0, 0));
        vecs.push_back(mk(ALUC_SRA,  32'd4,        32'h80000000, 4'd15, 32'hF8000000, 0, 0, 1));
        vecs.push_back(mk(ALUC_SLL,  32'd4,        32'd1,        4'd1,  32'h00000010, 0, 0, 0));
        vecs.push_back(mk(ALUC_SLA,  32'd31,       32'd1,        4'd2,  32'h80000000, 0, 0, 1));
        vecs.push_back(mk(ALUC_SRL,  32'd4,        32'h80000000, 4'd3,  32'h08000000, 0, 0, 0));
        vecs.push_back(mk(ALUC_MUL,  32'd6,        32'd7,        4'd4,  32'd42,       0, 0, 0));
        vecs.push_back(mk(ALUC_MUL,  32'h00010000, 32'h00010000, 4'd5,  32'd0,        1, 0, 0));
        vecs.push_back(mk(5'd20,     32'd3,        32'd4,        4'd6,  32'd0,        1, 0, 0));

        rsp_ready  = 2'b11;
        exp_rdy_en = 1'b1;
        exp_rdy    = 2'b01;
        foreach (vecs[i]) begin
            applyStimulus(0, 1'b1, vecs[i].aluc, vecs[i].a, vecs[i].b, vecs[i].tag);
            applyStimulus(1, 1'b0, 5'd0, 32'd0, 32'd0, '0);
            run_cycle();
            compare($sformatf("vec%0d_valid", i), rsp_valid[0], 1'b1);
            compare($sformatf("vec%0d_res", i), rsp_res[0], vecs[i].res);
            compare($sformatf("vec%0d_flags", i), {rsp_zero[0], rsp_carry[0], rsp_sign[0]},
                    {vecs[i].z, vecs[i].c, vecs[i].s});
            compare($sformatf("vec%0d_tag", i), rsp_tag[0], vecs[i].tag);
        end
        req_valid[0] = 1'b0;
        exp_rdy_en   = 1'b0;

        // Sustained contention right after reset: strict alternation from port 0
        resetDut();
        applyStimulus(0, 1'b1, ALUC_SUB, 32'd9, 32'd9, 4'd1);
        applyStimulus(1, 1'b1, ALUC_OR, 32'h000000F0, 32'h0000000F, 4'd2);
        rsp_ready  = 2'b11;
        exp_rdy_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            run_cycle();
        end
        compare("alt_zero0", rsp_zero[0], 1'b1);
        compare("alt_res1", rsp_res[1], 32'h000000FF);

        // Port 1 slot full and not drained: port 0 takes every grant
        rsp_ready = 2'b01;
        held_cnt  = 16'(mdl_cnt[1]);
        exp_rdy   = 2'b01;
        repeat (5) run_cycle();
        compare("blocked_cnt1", grant_cnt[1], held_cnt);
        rsp_ready = 2'b11;
        exp_rdy   = 2'b10;
        run_cycle();

        // Fill both slots, then reset asynchronously between edges
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        exp_rdy   = 2'b01;
        run_cycle();
        exp_rdy_en = 1'b0;
        compare("pre_rst_full", rsp_valid, 2'b11);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_rst_valid", rsp_valid, 2'b00);
        compare("async_rst_cnt", grant_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        rsp_ready  = 2'b11;
        exp_rdy_en = 1'b1;
        exp_rdy    = 2'b01;
        run_cycle();
        exp_rdy_en = 1'b0;

        // Randomized traffic
        req_valid = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && ($urandom % 4 != 0)) begin
                    applyStimulus(p, 1'b1,
                        ($urandom % 8 == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16)),
                        ($urandom % 4 == 0) ? 32'($urandom % 64) : $urandom,
                        ($urandom % 4 == 0) ? 32'($urandom % 64) : $urandom,
                        TAGW'($urandom));
                end
            end
            rsp_ready = 2'($urandom);
            if ($urandom % 3 != 0) rsp_ready = 2'b11;
            run_cycle();
            if (last_w >= 0) req_valid[last_w] = 1'b0;
        end

        // Counter saturation on port 0
        resetDut();
        applyStimulus(0, 1'b1, ALUC_ADDU, 32'd1, 32'd1, 4'd9);
        applyStimulus(1, 1'b0, 5'd0, 32'd0, 32'd0, '0);
        rsp_ready = 2'b01;
        do_check  = 1'b0;
        repeat (65540) run_cycle();
        do_check = 1'b1;
        compare("cnt_sat", grant_cnt[0], 16'hFFFF);
        run_cycle();
        compare("cnt_sat_hold", grant_cnt[0], 16'hFFFF);
        compare("cnt_other", grant_cnt[1], 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one instance of the core 32-bit ALU between two requesters, port 0 and port 1, for example the main pipeline and an address/branch helper unit. Each port has a valid/ready request channel and a valid/ready response channel. Grants are round-robin, one ALU operation per cycle. Each port's result and flags are registered and held until that port consumes them.

## Interface
- `NPORT`, 2: number of requesters; fixed at 2, not overridable.
- `TAGW`, 4: width of the opaque request tag echoed on the response.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid[p]`  in  1  port p holds a valid operation; p is 0 or 1.
- `req_ready[p]`  out  1  port p's operation is accepted this cycle.
- `req_a[p]`, `req_b[p]`  in  32  operands for port p.
- `req_aluc[p]`  in  5  ALU opcode for port p, using the shared-package encoding.
- `req_tag[p]`  in  TAGW  tag for port p, returned unchanged on the response.
- `rsp_valid[p]`  out  1  port p's response register is full.
- `rsp_ready[p]`  in  1  port p consumes its response this cycle.
- `rsp_res[p]`  out  32  result for port p.
- `rsp_zero[p]`, `rsp_carry[p]`, `rsp_sign[p]`  out  1 each  ALU flags for port p.
- `rsp_tag[p]`  out  TAGW  echoed tag for port p.
- `grant_cnt[p]`  out  16  saturating count of grants issued to port p.

## Operation
- A port is eligible when both hold: `req_valid[p]`, and `rsp_valid[p]==0 || rsp_ready[p]==1`. The second condition means its response slot is empty or is being drained this cycle.
- Arbitration:
  - Exactly one eligible port: that port is granted.
  - Both ports eligible: grant the port not named in `last_grant`.
  - `req_ready[p]` equals the grant for p. It is a combinational function of the inputs and `last_grant`.
- On a grant:
  - Drive the ALU with the granted port's A, B and ALUC through a 2:1 mux.
  - At the clock edge, load `rsp_res[p]`, the three flags and `rsp_tag[p]`, and set `rsp_valid[p]=1`.
  - Set `last_grant` to p.
  - Increment `grant_cnt[p]` unless it already reads 0xFFFF.
- Any cycle with `rsp_valid[p] && rsp_ready[p]` and no new grant to p clears `rsp_valid[p]`.
  - If p is granted in the same cycle, the register is overwritten and `rsp_valid[p]` stays 1.
- No grant in a cycle: the ALU inputs are don't-care and `last_grant` holds its value.
- Opcodes outside the defined encoding are still granted. The result is whatever the ALU produces; the arbiter does not check opcodes.
- Request inputs of a port need only be stable while `req_valid[p]` is high and `req_ready[p]` is low. Once asserted, `req_valid[p]` must not drop before the grant.

## Timing
- Reset, asynchronous, while `rst_n` is low:
  - `rsp_valid` 0 and `rsp_res` 0 for both ports.
  - All flags 0 and `rsp_tag` 0.
  - `grant_cnt` 0.
  - `last_grant` = 1, so port 0 wins the first contention.
- Reset asserted mid-operation discards any pending response immediately. No response survives reset.
- Latency: a grant in cycle N gives `rsp_valid` in cycle N+1.
- Throughput: one grant per cycle in total. A single port streams back-to-back when its `rsp_ready` is held high.
- Under sustained contention each port receives exactly every other grant.
- Full response slot with `rsp_ready` low: that port is ineligible and the other port receives every grant.
- `grant_cnt` wraps never; it sticks at 0xFFFF.

## Structure
- Shared package `alu_pkg`:
  - ALUC constants: ADDU=0, ADD=1, SUBU=2, SUB=3, AND=4, OR=5, XOR=6, NOR=7, LUI=8/9, SLT=10, SLTU=11, SRA=12, SLL=13, SLA=14, SRL=15, MUL=16.
  - The `alu_req_t` and `alu_rsp_t` field groupings.
- Sub-module `rr_arb2`: two-input round-robin arbiter holding the `last_grant` flop; outputs a one-hot grant.
- Top level contains the core ALU instance, the operand mux, the per-port response registers and the counters.

## Test plan
- After reset, port 0 only: ADD 5+7, tag 3 → `req_ready[0]`=1 in cycle 0; `rsp_res[0]`=12, `rsp_zero`=0, `rsp_tag`=3 in cycle 1.
- Both ports valid every cycle, all `rsp_ready` high: port 0 SUB 9-9, port 1 OR 0xF0|0x0F → grants alternate 0,1,0,1 starting with port 0. Port 0 results show `rsp_zero`=1; port 1 results are 0xFF.
- Port 1 `rsp_ready` held low with a full slot, both ports requesting → port 0 granted every cycle for 5 cycles and `grant_cnt[1]` unchanged. When `rsp_ready[1]` rises, port 1 is granted that same cycle.
- Simultaneous drain and refill on port 0 (SLT -1 vs 1, then SLTU -1 vs 1) → `rsp_valid[0]` stays 1; flags `sign`=1 then `sign`=0.
- `rst_n` pulled low mid-cycle while both response slots are full → all `rsp_valid` drop asynchronously. After release, the first contention grants port 0.
- 65540 grants to port 0 → `grant_cnt[0]` reads 0xFFFF and holds.
